fc_instr_wide_fetch: RTL and testbench

- Sits between the FC core instruction port (CFI_INSTR_WIDTH-wide read data) and the 32-bit L2 instruction TCDM port of the SoC interconnect.
- Accepts one wide instruction-fetch request at a time.
- Splits each request into NB_BEATS = CFI_INSTR_WIDTH/32 sequential 32-bit L2 reads, assembles the words and returns one wide response.
- Makes the CFI-extended instruction word usable on a plain 32-bit L2 bus.

---
 rtl/fc_instr_wide_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_fc_instr_wide_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_instr_wide_fetch.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fc_instr_wide_fetch
//
// Purpose:
//   Bridges the FC core instruction port (CFI_INSTR_WIDTH-wide read data) to
//   the 32-bit L2 instruction TCDM port. This block accepts one wide fetch at
//   a time. It issues NB_BEATS = CFI_INSTR_WIDTH/32 sequential 32-bit L2 reads
//   and assembles the words. It then returns the assembled data as a single
//   wide response. CFI_INSTR_WIDTH = 32 behaves as a registered single-beat
//   pass-through.
//
// Parameters:
//   CFI_INSTR_WIDTH - core-side read data width, multiple of 32, >= 32
//   ADDR_WIDTH      - address width on both sides
//
// Ports:
//   clk_i           - clock
//   rst_ni          - asynchronous active-low reset
//   instr_req_i     - core fetch request
//   instr_addr_i    - core fetch byte address (4-byte aligned)
//   instr_gnt_o     - request accepted (combinational, only in IDLE)
//   instr_rvalid_o  - one-cycle response strobe
//   instr_rdata_o   - assembled instruction data (registered, held)
//   instr_err_o     - error flag, valid with instr_rvalid_o (registered, held)
//   l2_req_o        - L2 request
//   l2_add_o        - L2 word address (base + 4*beat)
//   l2_wen_o        - constant 1 (read)
//   l2_be_o         - constant 4'b1111
//   l2_wdata_o      - constant 0
//   l2_gnt_i        - L2 grant
//   l2_r_valid_i    - L2 read response valid
//   l2_r_rdata_i    - L2 read data
//   l2_r_opc_i      - L2 error
//
// Optional feature macro:
//   FC_IFETCH_ERR_ABORT_EN - when defined, an erroring L2 beat ends the fetch
//   at once. The remaining words read as 0 and instr_err_o is set. When it is
//   undefined, all beats are always fetched and the errors are OR-accumulated.
// ----------------------------------------------------------------------------
module fc_instr_wide_fetch #(
    parameter int CFI_INSTR_WIDTH = 64,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       instr_req_i,
    input  logic [ADDR_WIDTH-1:0]      instr_addr_i,
    output logic                       instr_gnt_o,
    output logic                       instr_rvalid_o,
    output logic [CFI_INSTR_WIDTH-1:0] instr_rdata_o,
    output logic                       instr_err_o,

    output logic                       l2_req_o,
    output logic [ADDR_WIDTH-1:0]      l2_add_o,
    output logic                       l2_wen_o,
    output logic [3:0]                 l2_be_o,
    output logic [31:0]                l2_wdata_o,
    input  logic                       l2_gnt_i,
    input  logic                       l2_r_valid_i,
    input  logic [31:0]                l2_r_rdata_i,
    input  logic                       l2_r_opc_i
);

    localparam int NB_BEATS = CFI_INSTR_WIDTH / 32;
    // Keep the beat counter at least one bit wide so the single-beat build still
    // has a legal vector.
    localparam int BEAT_W   = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;

`ifdef FC_IFETCH_ERR_ABORT_EN
    localparam bit ERR_ABORT_EN = 1'b1;
`else
    localparam bit ERR_ABORT_EN = 1'b0;
`endif

    // Reject illegal widths at elaboration time.
    generate
        if (((CFI_INSTR_WIDTH % 32) != 0) || (CFI_INSTR_WIDTH < 32)) begin : g_bad_width
            $error("fc_instr_wide_fetch: CFI_INSTR_WIDTH must be a multiple of 32 and >= 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      base_q, base_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [CFI_INSTR_WIDTH-1:0] asm_q, asm_d;
    logic                       err_q, err_d;
    logic [CFI_INSTR_WIDTH-1:0] rdata_q, rdata_d;
    logic                       rerr_q, rerr_d;

    logic                       accept;
    logic                       beat_last;
    logic                       beat_done;
    logic                       finish;

    // Handshake qualifiers shared by the next-state and datapath logic.
    // "finish" marks the WAIT-to-RESP transition. The response registers load
    // on that edge so that they present the data during the RESP cycle.
    always_comb begin
        accept    = (state_q == ST_IDLE) && instr_req_i;
        beat_last = (beat_q == BEAT_W'(NB_BEATS - 1));
        beat_done = (state_q == ST_WAIT) && l2_r_valid_i;
        finish    = beat_done && (beat_last || (ERR_ABORT_EN && l2_r_opc_i));
    end

    // State register and all datapath flops. The reset is asynchronous, and
    // asserting it mid-transfer drops the in-flight beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_req_i) state_d = ST_REQ;
            ST_REQ:  if (l2_gnt_i)    state_d = ST_WAIT;
            ST_WAIT: begin
                if (l2_r_valid_i) begin
                    state_d = finish ? ST_RESP : ST_REQ;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values. The assembly register is cleared on acceptance,
    // so with error abort any words that were never fetched read as zero. The
    // response registers are kept separate from the assembly register. This
    // lets the core-visible data hold until the next response, even while a
    // new fetch is being assembled.
    always_comb begin
        base_d  = base_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;

        if (accept) begin
            base_d = instr_addr_i;
            beat_d = '0;
            asm_d  = '0;
            err_d  = 1'b0;
        end

        if (beat_done) begin
            for (int i = 0; i < NB_BEATS; i++) begin
                if (beat_q == BEAT_W'(i)) begin
                    asm_d[32*i +: 32] = l2_r_rdata_i;
                end
            end
            err_d = err_q | l2_r_opc_i;
            if (finish) begin
                rdata_d = asm_d;
                rerr_d  = err_d;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Output logic. The grant is combinational and is only given in IDLE. The
    // L2 address is derived from state, so it stays stable until the grant. It
    // wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        instr_gnt_o    = accept;
        instr_rvalid_o = (state_q == ST_RESP);
        instr_rdata_o  = rdata_q;
        instr_err_o    = rerr_q;
        l2_req_o       = (state_q == ST_REQ);
        l2_add_o       = (state_q == ST_REQ) ? (base_q + (ADDR_WIDTH'(beat_q) << 2)) : '0;
        l2_wen_o       = 1'b1;
        l2_be_o        = 4'hF;
        l2_wdata_o     = 32'h0;
    end

endmodule

// File: tb/tb_fc_instr_wide_fetch.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_fc_instr_wide_fetch
//
// Directed bench for fc_instr_wide_fetch at CFI_INSTR_WIDTH = 64.
// A behavioural L2 slave serves the beats that each test queues. It also
// checks the address of each beat, how the grant and request are held, and
// that only one transaction is outstanding at a time. A monitor pops the
// expected wide responses whenever instr_rvalid_o is seen.
// ----------------------------------------------------------------------------
module tb_fc_instr_wide_fetch;

    localparam int W  = 64;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [W-1:0]  instr_rdata_o;
    logic          instr_err_o;
    logic          l2_req_o;
    logic [AW-1:0] l2_add_o;
    logic          l2_wen_o;
    logic [3:0]    l2_be_o;
    logic [31:0]   l2_wdata_o;
    logic          l2_gnt_i;
    logic          l2_r_valid_i;
    logic [31:0]   l2_r_rdata_i;
    logic          l2_r_opc_i;

    always #5 clk_i = ~clk_i;

    fc_instr_wide_fetch #(
        .CFI_INSTR_WIDTH (W),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .l2_req_o       (l2_req_o),
        .l2_add_o       (l2_add_o),
        .l2_wen_o       (l2_wen_o),
        .l2_be_o        (l2_be_o),
        .l2_wdata_o     (l2_wdata_o),
        .l2_gnt_i       (l2_gnt_i),
        .l2_r_valid_i   (l2_r_valid_i),
        .l2_r_rdata_i   (l2_r_rdata_i),
        .l2_r_opc_i     (l2_r_opc_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        opc;
        int          gnt_delay;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    int          gnt_cyc_q[$];

    int          tests_run   = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          last_rvalid_cyc = -100;
    bit          pend         = 1'b0;
    logic [31:0] pend_data    = '0;
    logic        pend_opc     = 1'b0;
    int          wait_cnt     = 0;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural L2 slave. It is driven on the falling edge. After the
    // configured number of wait cycles it grants the request, and the read
    // data follows one cycle after the grant.
    always @(negedge clk_i) begin
        l2_gnt_i     = 1'b0;
        l2_r_valid_i = 1'b0;
        l2_r_rdata_i = 32'h0;
        l2_r_opc_i   = 1'b0;
        if (pend) begin
            if (l2_req_o) checkOutput("l2_overlap", 64'd1, 64'd0);
            l2_r_valid_i = 1'b1;
            l2_r_rdata_i = pend_data;
            l2_r_opc_i   = pend_opc;
            pend         = 1'b0;
        end else if (!rst_ni) begin
            wait_cnt = 0;
        end else if (l2_req_o) begin
            if (beat_q.size() == 0) begin
                checkOutput("l2_unexpected_req", 64'd1, 64'd0);
                l2_gnt_i  = 1'b1;
                pend      = 1'b1;
                pend_data = 32'h0;
                pend_opc  = 1'b0;
            end else begin
                checkOutput("l2_addr", 64'(l2_add_o), 64'(beat_q[0].addr));
                if (wait_cnt == beat_q[0].gnt_delay) begin
                    l2_gnt_i  = 1'b1;
                    pend      = 1'b1;
                    pend_data = beat_q[0].data;
                    pend_opc  = beat_q[0].opc;
                    void'(beat_q.pop_front());
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end else if (wait_cnt != 0) begin
            checkOutput("l2_req_dropped", 64'd0, 64'd1);
            wait_cnt = 0;
        end
    end

    // Response monitor: every strobe must match the oldest expected response,
    // both in data and in latency from its grant.
    always @(negedge clk_i) begin
        if (instr_rvalid_o) begin
            resp_t r;
            int    g;
            last_rvalid_cyc = cyc;
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                r = resp_q.pop_front();
                checkOutput("rdata", instr_rdata_o, r.data);
                checkOutput("err", 64'(instr_err_o), 64'(r.err));
                if (gnt_cyc_q.size() != 0) begin
                    g = gnt_cyc_q.pop_front();
                    checkOutput("latency", 64'(cyc - g), 64'(r.lat));
                end else begin
                    checkOutput("gnt_missing", 64'd1, 64'd0);
                end
            end
        end
    end

    task automatic queueBeat(input logic [31:0] addr, input logic [31:0] data, input logic opc, input int dly);
        beat_t b;
        b.addr = addr;
        b.data = data;
        b.opc  = opc;
        b.gnt_delay = dly;
        beat_q.push_back(b);
    endtask

    task automatic pushResp(input logic [63:0] data, input logic err, input int lat);
        resp_t r;
        r.data = data;
        r.err  = err;
        r.lat  = lat;
        resp_q.push_back(r);
    endtask

    task automatic waitDone();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (resp_q.size() == 0 && beat_q.size() == 0 && !pend) done = 1'b1;
            else @(negedge clk_i);
        end
        checkOutput("txn_complete", 64'(done), 64'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] exp_data,
                                 input logic exp_err, input int exp_lat);
        bit got = 1'b0;
        pushResp(exp_data, exp_err, exp_lat);
        @(negedge clk_i);
        instr_req_i  = 1'b1;
        instr_addr_i = addr;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (instr_gnt_o) begin
                gnt_cyc_q.push_back(cyc);
                got = 1'b1;
            end else begin
                @(negedge clk_i);
            end
        end
        checkOutput("gnt_seen", 64'(got), 64'd1);
        @(negedge clk_i);
        instr_req_i = 1'b0;
        waitDone();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"},    64'(instr_gnt_o),    64'd0);
        checkOutput({tag, "_rvalid"}, 64'(instr_rvalid_o), 64'd0);
        checkOutput({tag, "_rdata"},  instr_rdata_o,       64'd0);
        checkOutput({tag, "_err"},    64'(instr_err_o),    64'd0);
        checkOutput({tag, "_l2req"},  64'(l2_req_o),       64'd0);
        checkOutput({tag, "_l2add"},  64'(l2_add_o),       64'd0);
        checkOutput({tag, "_wen"},    64'(l2_wen_o),       64'd1);
        checkOutput({tag, "_be"},     64'(l2_be_o),        64'hF);
        checkOutput({tag, "_wdata"},  64'(l2_wdata_o),     64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ngnt;
        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        l2_gnt_i     = 1'b0;
        l2_r_valid_i = 1'b0;
        l2_r_rdata_i = '0;
        l2_r_opc_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 checkResetOutputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("[TB] zero-wait 64-bit fetch");
        queueBeat(32'h1C000080, 32'h11111111, 1'b0, 0);
        queueBeat(32'h1C000084, 32'h22222222, 1'b0, 0);
        applyStimulus(32'h1C000080, 64'h22222222_11111111, 1'b0, 5);
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rdata_hold", instr_rdata_o, 64'h22222222_11111111);
        checkOutput("rvalid_low", 64'(instr_rvalid_o), 64'd0);

        $display("[TB] grant stall on beat 1");
        queueBeat(32'h1C000400, 32'hDEADBEEF, 1'b0, 0);
        queueBeat(32'h1C000404, 32'hCAFEF00D, 1'b0, 3);
        applyStimulus(32'h1C000400, 64'hCAFEF00D_DEADBEEF, 1'b0, 8);

        $display("[TB] error on beat 0");
        queueBeat(32'h1C000500, 32'h12345678, 1'b1, 0);
`ifdef FC_IFETCH_ERR_ABORT_EN
        applyStimulus(32'h1C000500, 64'h00000000_12345678, 1'b1, 3);
`else
        queueBeat(32'h1C000504, 32'h9ABCDEF0, 1'b0, 0);
        applyStimulus(32'h1C000500, 64'h9ABCDEF0_12345678, 1'b1, 5);
`endif

        $display("[TB] error on last beat");
        queueBeat(32'h1C000600, 32'h0BADF00D, 1'b0, 0);
        queueBeat(32'h1C000604, 32'h600DCAFE, 1'b1, 0);
        applyStimulus(32'h1C000600, 64'h600DCAFE_0BADF00D, 1'b1, 5);

        $display("[TB] clean fetch after error");
        queueBeat(32'h1C000700, 32'h01020304, 1'b0, 0);
        queueBeat(32'h1C000704, 32'h05060708, 1'b0, 0);
        applyStimulus(32'h1C000700, 64'h05060708_01020304, 1'b0, 5);

        $display("[TB] address wrap");
        queueBeat(32'hFFFFFFFC, 32'hA5A5A5A5, 1'b0, 0);
        queueBeat(32'h00000000, 32'h5A5A5A5A, 1'b0, 0);
        applyStimulus(32'hFFFFFFFC, 64'h5A5A5A5A_A5A5A5A5, 1'b0, 5);

        $display("[TB] continuous core request");
        queueBeat(32'h1C000800, 32'h11112222, 1'b0, 0);
        queueBeat(32'h1C000804, 32'h33334444, 1'b0, 0);
        queueBeat(32'h1C000900, 32'h55556666, 1'b0, 0);
        queueBeat(32'h1C000904, 32'h77778888, 1'b0, 0);
        pushResp(64'h33334444_11112222, 1'b0, 5);
        pushResp(64'h77778888_55556666, 1'b0, 5);
        ngnt = 0;
        @(negedge clk_i);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h1C000800;
        for (int k = 0; k < 100 && ngnt < 2; k++) begin
            #1;
            if (instr_gnt_o) begin
                ngnt++;
                gnt_cyc_q.push_back(cyc);
                if (ngnt == 2) checkOutput("regrant_cycle", 64'(cyc), 64'(last_rvalid_cyc + 1));
            end
            @(negedge clk_i);
            if (ngnt == 1) instr_addr_i = 32'h1C000900;
        end
        instr_req_i = 1'b0;
        checkOutput("two_grants", 64'(ngnt), 64'd2);
        waitDone();

        $display("[TB] reset during WAIT");
        queueBeat(32'h1C000300, 32'hAAAA5555, 1'b0, 0);
        queueBeat(32'h1C000304, 32'h5555AAAA, 1'b0, 0);
        @(negedge clk_i);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h1C000300;
        @(negedge clk_i);
        instr_req_i  = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1 checkResetOutputs("midreset");
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        beat_q.delete();
        repeat (3) @(negedge clk_i);
        #1 checkResetOutputs("postreset");

        $display("[TB] fetch after reset");
        queueBeat(32'h1C000A00, 32'h0F0F0F0F, 1'b0, 0);
        queueBeat(32'h1C000A04, 32'hF0F0F0F0, 1'b0, 0);
        applyStimulus(32'h1C000A00, 64'hF0F0F0F0_0F0F0F0F, 1'b0, 5);

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
